// File: rtl/seg7_display_arbiter.sv
// Time-shares a 4-digit 7-segment display between a base source and two
// event requesters; ev1 has priority, events are held for TICK_DIV*HOLD_TICKS cycles.
module seg7_display_arbiter #(
  parameter int TICK_DIV   = 10000000,
  parameter int HOLD_TICKS = 20,
  parameter bit BLINK_EV1  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] base_val,
  input  logic        ev0_req,
  input  logic [15:0] ev0_val,
  input  logic        ev1_req,
  input  logic [15:0] ev1_val,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        disp_blank,
  output logic [1:0]  active_src,
  output logic        busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  // Encoding doubles as the active_src code.
  typedef enum logic [1:0] {
    ST_BASE  = 2'd0,
    ST_SHOW0 = 2'd1,
    ST_SHOW1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   latch0_q, latch0_d;
  logic [15:0]   latch1_q, latch1_d;
  logic          pend0_q, pend0_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   digits_q, digits_d;
  logic          blank_q, blank_d;
  logic          busy_q, busy_d;
  logic          tick, hold_done, restart;

  assign tick      = (pre_q == PRE_LAST);
  assign hold_done = tick && (hold_q == HOLD_LAST);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    pend0_d  = pend0_q;
    latch0_d = ev0_req ? ev0_val : latch0_q;
    latch1_d = ev1_req ? ev1_val : latch1_q;
    restart  = 1'b0;

    unique case (state_q)
      ST_BASE: begin
        if (ev1_req) begin
          state_d = ST_SHOW1;
          restart = 1'b1;
          pend0_d = pend0_q | ev0_req;
        end else if (ev0_req) begin
          state_d = ST_SHOW0;
          restart = 1'b1;
        end
      end
      ST_SHOW0: begin
        // A preempted ev0 display is dropped; only a fresh ev0 request pends.
        if (ev1_req) begin
          state_d = ST_SHOW1;
          restart = 1'b1;
          pend0_d = ev0_req;
        end else if (ev0_req) begin
          restart = 1'b1;
        end else if (hold_done) begin
          state_d = ST_BASE;
        end
      end
      ST_SHOW1: begin
        if (ev1_req) begin
          restart = 1'b1;
          pend0_d = pend0_q | ev0_req;
        end else if (hold_done) begin
          if (ev0_req || pend0_q) begin
            state_d = ST_SHOW0;
            restart = 1'b1;
          end else begin
            state_d = ST_BASE;
          end
        end else begin
          pend0_d = pend0_q | ev0_req;
        end
      end
      default: state_d = ST_BASE;
    endcase

    if (state_d == ST_SHOW0) pend0_d = 1'b0;

    // Hold timer: runs only while a SHOW state is kept; any entry or exit clears it.
    if (!restart && (state_q != ST_BASE) && (state_d == state_q)) begin
      if (tick) begin
        pre_d  = '0;
        hold_d = hold_q + HW'(1);
      end else begin
        pre_d  = pre_q + PW'(1);
        hold_d = hold_q;
      end
    end else begin
      pre_d  = '0;
      hold_d = '0;
    end

    unique case (state_d)
      ST_SHOW0: digits_d = latch0_d;
      ST_SHOW1: digits_d = latch1_d;
      default:  digits_d = base_val;
    endcase

    blank_d = (BLINK_EV1 && (state_d == ST_SHOW1)) ? hold_d[0] : 1'b0;
    busy_d  = (state_d != ST_BASE) || pend0_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BASE;
      latch0_q <= '0;
      latch1_q <= '0;
      pend0_q  <= 1'b0;
      pre_q    <= '0;
      hold_q   <= '0;
      digits_q <= '0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      latch0_q <= latch0_d;
      latch1_q <= latch1_d;
      pend0_q  <= pend0_d;
      pre_q    <= pre_d;
      hold_q   <= hold_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
    end
  end

  assign digit3     = digits_q[15:12];
  assign digit2     = digits_q[11:8];
  assign digit1     = digits_q[7:4];
  assign digit0     = digits_q[3:0];
  assign disp_blank = blank_q;
  assign active_src = state_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Bench for seg7_display_arbiter: directed scenarios with literal expectations plus
// random traffic, all compared every cycle against an elapsed-time behavioural model.
module tb_seg7_display_arbiter;

  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 3;
  localparam int TOT        = TICK_DIV * HOLD_TICKS;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] base_val, ev0_val, ev1_val;
  logic        ev0_req, ev1_req;
  logic [3:0]  digit3, digit2, digit1, digit0;
  logic        disp_blank, busy;
  logic [1:0]  active_src;

  always #5 clk = ~clk;

  seg7_display_arbiter #(
    .TICK_DIV  (TICK_DIV),
    .HOLD_TICKS(HOLD_TICKS),
    .BLINK_EV1 (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .base_val  (base_val),
    .ev0_req   (ev0_req),
    .ev0_val   (ev0_val),
    .ev1_req   (ev1_req),
    .ev1_val   (ev1_val),
    .digit3    (digit3),
    .digit2    (digit2),
    .digit1    (digit1),
    .digit0    (digit0),
    .disp_blank(disp_blank),
    .active_src(active_src),
    .busy      (busy)
  );

  wire [15:0] digits_w = {digit3, digit2, digit1, digit0};

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: which source is shown, cycles elapsed since it was entered, ev0 backlog.
  typedef struct {
    int          src;
    int          e;
    bit          pend0;
    logic [15:0] l0;
    logic [15:0] l1;
    logic [15:0] base;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.src = 0; n.e = 0; n.pend0 = 1'b0;
    n.l0 = '0; n.l1 = '0; n.base = '0;
    return n;
  endfunction

  function automatic model_t model_step(model_t c, bit r0, logic [15:0] v0,
                                        bit r1, logic [15:0] v1, logic [15:0] b);
    model_t n = c;
    n.base = b;
    if (r0) n.l0 = v0;
    if (r1) n.l1 = v1;
    if (r1) begin
      n.src = 2; n.e = 0;
      if (c.src == 1) n.pend0 = r0;
      else if (r0) n.pend0 = 1'b1;
    end else begin
      case (c.src)
        0: if (r0) begin n.src = 1; n.e = 0; end
        1: begin
          if (r0) n.e = 0;
          else if (c.e == TOT - 1) n.src = 0;
          else n.e = c.e + 1;
        end
        default: begin
          if (c.e == TOT - 1) begin
            if (r0 || c.pend0) begin n.src = 1; n.e = 0; n.pend0 = 1'b0; end
            else n.src = 0;
          end else begin
            n.e = c.e + 1;
            if (r0) n.pend0 = 1'b1;
          end
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, ev0_req, ev0_val, ev1_req, ev1_val, base_val);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("digits", {16'h0, digits_w},
            {16'h0, (m.src == 0) ? m.base : ((m.src == 1) ? m.l0 : m.l1)});
      check("active_src", {30'h0, active_src}, m.src);
      check("disp_blank", {31'h0, disp_blank},
            {31'h0, (m.src == 2) && (((m.e / TICK_DIV) % 2) == 1)});
      check("busy", {31'h0, busy}, {31'h0, (m.src != 0) || m.pend0});
    end
  end

  task automatic pulse(input bit r0, input logic [15:0] v0, input bit r1, input logic [15:0] v1);
    ev0_req = r0; ev0_val = v0;
    ev1_req = r1; ev1_val = v1;
    @(negedge clk);
    ev0_req = 1'b0;
    ev1_req = 1'b0;
  endtask

  // Samples n cycles, counting ev0/ev1 display cycles and the ev1 blink pattern.
  task automatic measure(input int n, output int c1, output int c2, output logic [15:0] pat);
    c1 = 0; c2 = 0; pat = '0;
    for (int i = 0; i < n; i++) begin
      if (active_src == 2'd1) c1++;
      if (active_src == 2'd2) begin
        c2++;
        pat = {pat[14:0], disp_blank};
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int c1, c2, c1a;
    logic [15:0] pat;

    rst = 1'b1;
    base_val = 16'h1234;
    ev0_req = 1'b0; ev0_val = '0;
    ev1_req = 1'b0; ev1_val = '0;
    repeat (2) @(negedge clk);
    check("reset_digits", {16'h0, digits_w}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    cmp_en = 1'b1;

    // 1: base tracking after reset release
    rst = 1'b0;
    @(negedge clk);
    check("t1_digits", {16'h0, digits_w}, 32'h1234);
    check("t1_src", {30'h0, active_src}, 32'd0);
    check("t1_busy_blank", {30'h0, busy, disp_blank}, 32'd0);

    // 2: single ev0 event
    pulse(1'b1, 16'h00AB, 1'b0, 16'h0);
    check("t2_digits", {16'h0, digits_w}, 32'h00AB);
    check("t2_busy", {31'h0, busy}, 32'd1);
    measure(20, c1, c2, pat);
    check("t2_ev0_cycles", c1, 32'd12);
    check("t2_return", {15'h0, busy, digits_w}, 32'h1234);

    // 3: simultaneous requests, ev1 first with blink, then pending ev0
    pulse(1'b1, 16'h0005, 1'b1, 16'hEEEE);
    check("t3_digits", {16'h0, digits_w}, 32'hEEEE);
    measure(30, c1, c2, pat);
    check("t3_ev1_cycles", c2, 32'd12);
    check("t3_ev0_cycles", c1, 32'd12);
    check("t3_blink", {16'h0, pat}, 32'h00F0);
    check("t3_src", {30'h0, active_src}, 32'd0);

    // 4: ev1 preempts ev0 five cycles in; ev0 is not shown again
    pulse(1'b1, 16'h0077, 1'b0, 16'h0);
    measure(4, c1a, c2, pat);
    pulse(1'b0, 16'h0, 1'b1, 16'h4321);
    check("t4_digits", {16'h0, digits_w}, 32'h4321);
    measure(24, c1, c2, pat);
    check("t4_ev0_before", c1a + 1, 32'd5);
    check("t4_ev1_cycles", c2, 32'd12);
    check("t4_ev0_after", c1, 32'd0);

    // 5: ev0 retrigger restarts the hold with the new value
    pulse(1'b1, 16'h0A0A, 1'b0, 16'h0);
    measure(7, c1a, c2, pat);
    pulse(1'b1, 16'h0B0B, 1'b0, 16'h0);
    check("t5_digits", {16'h0, digits_w}, 32'h0B0B);
    measure(20, c1, c2, pat);
    check("t5_total", c1a + 1 + c1, 32'd20);

    // 6: reset during SHOW1 with ev0 pending
    pulse(1'b1, 16'h0005, 1'b1, 16'hEEEE);
    measure(5, c1, c2, pat);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_digits", {16'h0, digits_w}, 32'h0);
    check("t6_rst_flags", {29'h0, active_src, busy}, 32'd0);
    check("t6_rst_blank", {31'h0, disp_blank}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    measure(30, c1, c2, pat);
    check("t6_no_events", c1 + c2, 32'd0);
    check("t6_digits", {16'h0, digits_w}, 32'h1234);

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 2000; i++) begin
      base_val = 16'($urandom);
      ev0_val  = 16'($urandom);
      ev1_val  = 16'($urandom);
      ev0_req  = ($urandom_range(0, 11) == 0);
      ev1_req  = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end
    ev0_req = 1'b0;
    ev1_req = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
